// File: rtl/ad463x_adc_model.sv
// ad463x_adc_model: clocked behavioural AD463x model; converts on cnv, serialises words over
// NUM_OF_SDI lanes on falling SCLK, and echoes SCLK after a fixed clk delay.
module ad463x_adc_model #(
    parameter int NUM_OF_SDI = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CONV_CYCLES = 30,
    parameter int ECHO_DELAY = 18,
    parameter logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(32'hA5A50000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnv,
    input  logic                  spi_cs,
    input  logic                  spi_sclk,
    output logic [NUM_OF_SDI-1:0] spi_sdi,
    output logic                  echo_sclk,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    output logic [7:0]            cnv_ignored
);
    localparam int L = DATA_WIDTH / NUM_OF_SDI;
    localparam int CW = $clog2(CONV_CYCLES) + 1;
    localparam int BW = $clog2(L) + 1;

    typedef enum logic [2:0] {IDLE, CONVERT, READY, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    cnv_q1, cnv_q2, cs_q1, cs_q2, sclk_q1, sclk_q2;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d, sr_q, sr_d, data_q, data_d;
    logic                    valid_q, valid_d;
    logic [7:0]              ign_q, ign_d;
    logic [ECHO_DELAY-1:0]   echo_q;
    logic                    cnv_rise, cs_rise, sclk_fall, conv_done, shift_en;
    logic [NUM_OF_SDI-1:0]   msb;

    assign cnv_rise  = cnv_q1 & ~cnv_q2;
    assign cs_rise   = cs_q1 & ~cs_q2;
    assign sclk_fall = ~sclk_q1 & sclk_q2;
    assign conv_done = (state_q == CONVERT) && (cnt_q == '0);
    // cs_q1 low also makes a simultaneous cs rise win over an sclk fall
    assign shift_en  = (state_q == READY || state_q == SHIFT) && sclk_fall && !cs_q1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {cnv_q1, cnv_q2, cs_q1, cs_q2, sclk_q1, sclk_q2} <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            word_q  <= SEED;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ign_q   <= '0;
            echo_q  <= '0;
        end else begin
            {cnv_q1, cnv_q2} <= {cnv, cnv_q1};
            {cs_q1, cs_q2}   <= {spi_cs, cs_q1};
            {sclk_q1, sclk_q2} <= {spi_sclk, sclk_q1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ign_q   <= ign_d;
            echo_q  <= ECHO_DELAY'({echo_q, spi_sclk});
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = cnv_rise ? CONVERT : IDLE;
            CONVERT: state_d = conv_done ? READY : CONVERT;
            default: state_d = cnv_rise ? CONVERT :
                               (cs_rise && state_q != READY) ? IDLE :
                               shift_en ? ((bit_q == BW'(L - 1)) ? DONE : SHIFT) : state_q;
        endcase
        cnt_d   = (cnv_rise && state_q != CONVERT) ? CW'(CONV_CYCLES - 1) :
                  (state_q == CONVERT) ? cnt_q - CW'(1) : cnt_q;
        word_d  = conv_done ? word_q + DATA_WIDTH'(1) : word_q;
        data_d  = conv_done ? word_q : data_q;
        valid_d = conv_done;
        // a plain left shift is enough: bits leaking in from the lower lane only reach a lane MSB after the word ends
        sr_d    = conv_done ? word_q : shift_en ? sr_q << 1 : sr_q;
        bit_d   = conv_done ? '0 : shift_en ? bit_q + BW'(1) : bit_q;
        ign_d   = (state_q == CONVERT && cnv_rise && ign_q != 8'hFF) ? ign_q + 8'd1 : ign_q;
    end

    always_comb begin
        msb = '0;
        for (int k = 0; k < NUM_OF_SDI; k++) msb[k] = sr_q[k*L + L - 1];
        spi_sdi = ((state_q == READY || state_q == SHIFT) && !cs_q1) ? msb : '0;
        busy    = state_q == CONVERT;
    end

    assign echo_sclk    = echo_q[ECHO_DELAY-1];
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign cnv_ignored  = ign_q;
endmodule

// File: doc/ad463x_adc_model.md
Name: ad463x_adc_model

Overview:
- Synthesizable clocked behavioural model of the AD463x converter; sits directly downstream of the SPI engine/CNV generator in the ad463x bench and drives the data lanes back into it.
- Consumes cnv, spi_cs and spi_sclk; produces busy, the NUM_OF_SDI serial data lanes and a delayed echo clock.
- Exposes each converted word plus a valid strobe so the test program can score received samples.
- Runs on one fast oversampling clock, at least 10x the SCLK rate.

Parameters:
- NUM_OF_SDI, 4: data lanes; legal values 1, 2, 4, 8.
- DATA_WIDTH, 32: bits per conversion word; must be divisible by NUM_OF_SDI.
- CONV_CYCLES, 30: clk cycles busy stays high per conversion (>=1).
- ECHO_DELAY, 18: clk cycles of delay from spi_sclk to echo_sclk (>=1).
- SEED, 32'hA5A50000: value of the first converted word.

Ports:
- clk, input, 1: oversampling clock.
- rst, input, 1: asynchronous, active-high reset.
- cnv, input, 1: conversion start; rising edge is significant.
- spi_cs, input, 1: active-low chip select.
- spi_sclk, input, 1: serial clock from the SPI engine.
- spi_sdi, output, NUM_OF_SDI: serial data lanes toward the host.
- echo_sclk, output, 1: spi_sclk delayed ECHO_DELAY clk cycles.
- busy, output, 1: conversion in progress.
- sample_data, output, DATA_WIDTH: word produced by the latest conversion.
- sample_valid, output, 1: one-cycle strobe when sample_data updates.
- cnv_ignored, output, 8: saturating count of rejected cnv edges.

Behaviour:
- Reset values:
  - busy, sample_valid and echo_sclk are 0.
  - spi_sdi is all 0 and cnv_ignored is 0.
  - sample_data is 0; the internal word counter loads SEED.
  - The FSM goes to IDLE and the echo shift register clears.
- Input registration: cnv, spi_cs and spi_sclk pass through two register stages (q1, q2).
  - Edges are taken from q1 against q2, so every input edge is seen 2 clk edges after it is sampled.
- FSM states: IDLE, CONVERT, READY, SHIFT, DONE.
- IDLE:
  - On a cnv rise, go to CONVERT, set busy=1 and load the conversion counter with CONV_CYCLES-1.
- CONVERT:
  - Decrement the counter each cycle. When it reaches 0, in the same cycle:
    - busy=0, sample_data=word counter, sample_valid=1 for that cycle;
    - the word counter increments modulo 2^DATA_WIDTH;
    - the lane shift registers load the word;
    - go to READY.
  - A cnv rise during CONVERT is ignored and increments cnv_ignored (saturates at 255).
- Lane mapping:
  - L = DATA_WIDTH/NUM_OF_SDI.
  - Lane k carries word bits [(k+1)*L-1 : k*L], MSB first.
- READY and SHIFT:
  - In READY with spi_cs_q1 low, every lane drives its slice MSB.
  - Host samples on rising SCLK; the model advances on falling SCLK.
  - Each detected sclk fall shifts all lanes by one bit and increments a bit counter. The first fall moves READY to SHIFT.
  - After the L-th fall, go to DONE and drive spi_sdi to 0.
  - Extra sclk edges in DONE have no effect.
- cs handling:
  - spi_sdi is forced to 0 whenever spi_cs_q1 is high.
  - A cs rise in SHIFT (aborted read) goes to IDLE; the remaining bits are discarded.
  - A cs rise in DONE goes to IDLE.
  - In READY, cs high keeps the word and the state.
- New cnv rise in READY, SHIFT or DONE: start a new conversion (go to CONVERT) and discard the unread word.
  - This does not count in cnv_ignored.
- echo_sclk: bit ECHO_DELAY-1 of a shift register clocked every clk cycle from raw spi_sclk. It is independent of the FSM and of cs.
- Simultaneous events in the same cycle:
  - cs rise and sclk fall: cs wins, no shift.
  - cnv rise and counter reaching 0 in CONVERT: the conversion completes and the cnv rise counts as ignored.
- Reset mid-operation returns immediately to the reset values listed above.

Test Plan:
- Single read, NUM_OF_SDI=4, DATA_WIDTH=32, SEED=32'hA5A50000:
  - Stimulus: cnv pulse, then cs low and 8 SCLK periods.
  - Expected: busy high for exactly 30 clk; sample_valid pulses once with sample_data 32'hA5A50000.
  - Expected lanes, MSB first: lane3 = 8'hA5, lane2 = 8'hA5, lane1 = 8'h00, lane0 = 8'h00.
- Back-to-back conversions:
  - Stimulus: three cnv/read cycles.
  - Expected: words A5A50000, A5A50001, A5A50002; with SEED=32'hFFFFFFFF the second word is 0 (wrap-around).
- cnv during busy:
  - Stimulus: second cnv rise 10 clk after the first.
  - Expected: busy still drops 30 clk after the first edge; cnv_ignored=1.
  - After 300 such edges, cnv_ignored=255.
- Aborted read:
  - Stimulus: cs deasserted after 3 SCLK falls, then new cnv and full read.
  - Expected: spi_sdi=0 while cs is high; the next read returns the following word starting at its MSB.
- Echo delay:
  - Stimulus: free-running spi_sclk.
  - Expected: echo_sclk equals spi_sclk shifted exactly 18 clk cycles.
- Reset:
  - Stimulus: rst asserted mid-SHIFT.
  - Expected: busy, spi_sdi and echo_sclk go to 0 at once; the next conversion returns SEED.
